// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small byte FIFO in front of the line FSM
module uart_tx #(
    parameter int CPB        = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_full,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CPB > 2) ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          wr_en, pop, fifo_empty;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, done_n, bit_end;

    // Writes are gated by the registered full flag only, so a pop on the
    // same edge never rescues a write that arrives while full.
    assign wr_en      = tx_start & ~tx_full;
    assign fifo_empty = (count == '0);
    assign bit_end    = (cnt == CW'(CPB - 1));

    always_comb begin
        count_n = count;
        case ({wr_en, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_full <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count   <= count_n;
            tx_full <= (count_n == (AW+1)'(FIFO_DEPTH));
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        done_n  = 1'b0;
        pop     = 1'b0;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = shift >> 1;
                        idx_n   = idx + 3'd1;
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_n = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            tx_busy <= (state_n != IDLE);
            tx_done <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx at CPB=16 and CPB=2
module tb_uart_tx;
    localparam int CPB  = 16;
    localparam int CPB2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_start, tx_start2;
    logic       tx_full, tx, tx_busy, tx_done;
    logic       tx_full2, tx2, tx_busy2, tx_done2;

    uart_tx #(.CPB(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.CPB(CPB2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_start(tx_start2),
        .tx_full(tx_full2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[5];

    logic [9:0] r_bits;
    int r_waits, r_glitch, r_done_in, r_busy_low, r_t0, r_t1;
    bit r_done_after, r_line_after, r_busy_after, r_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic line_v(bit sel);
        return sel ? tx2 : tx;
    endfunction
    function automatic logic done_v(bit sel);
        return sel ? tx_done2 : tx_done;
    endfunction
    function automatic logic busy_v(bit sel);
        return sel ? tx_busy2 : tx_busy;
    endfunction

    // Samples one frame at negedges starting from the first low sample,
    // then one extra sample where tx_done must be high.
    task automatic recv(input bit sel, input int cpb);
        logic v;
        r_waits = 0; r_glitch = 0; r_done_in = 0; r_busy_low = 0;
        r_timeout = 0; r_bits = '0;
        while (line_v(sel) !== 1'b0 && r_waits < 20 * cpb + 50) begin
            @(negedge clk);
            r_waits++;
        end
        if (line_v(sel) !== 1'b0) begin
            r_timeout = 1;
            check("frame_start_timeout", 1, 0);
            return;
        end
        r_t0 = cyc;
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            v = line_v(sel);
            if (k % cpb == 0) r_bits[k / cpb] = v;
            else if (v !== r_bits[k / cpb]) r_glitch++;
            if (k > 0 && done_v(sel) !== 1'b0) r_done_in++;
            if (busy_v(sel) !== 1'b1) r_busy_low++;
        end
        @(negedge clk);
        r_t1 = cyc;
        r_done_after = done_v(sel);
        r_line_after = line_v(sel);
        r_busy_after = busy_v(sel);
    endtask

    task automatic write_byte(input bit sel, input logic [7:0] d);
        if (sel) begin tx_data2 = d; tx_start2 = 1'b1; end
        else     begin tx_data  = d; tx_start  = 1'b1; end
        @(negedge clk);
        tx_start = 1'b0;
        tx_start2 = 1'b0;
    endtask

    int quiet_low, quiet_done;

    initial begin
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA3, 10'b1101000110};
        vecs[2] = '{8'h00, 10'b1000000000};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'hC3, 10'b1110000110};

        rst = 1'b1; tx_start = 1'b0; tx_start2 = 1'b0;
        tx_data = 8'h00; tx_data2 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_full", tx_full, 0);
        check("reset_tx2", tx2, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            write_byte(0, vecs[i].data);
            recv(0, CPB);
            if (!r_timeout) begin
                check($sformatf("frame_%02h", vecs[i].data), r_bits, vecs[i].frame);
                check("start_latency", r_waits, 1);
                check("bit_hold", r_glitch, 0);
                check("done_inside_frame", r_done_in, 0);
                check("busy_during_frame", r_busy_low, 0);
                check("done_after_stop", r_done_after, 1);
                check("idle_line_after", r_line_after, 1);
                check("busy_after", r_busy_after, 0);
            end
            @(negedge clk);
            check("done_one_cycle", tx_done, 0);
        end

        // FIFO fill: 0x01 pops immediately, 0x02..0x05 fill, 0x99 is dropped.
        fork
            begin
                tx_data = 8'h01; tx_start = 1'b1;
                for (int d = 2; d <= 5; d++) begin
                    @(negedge clk);
                    tx_data = 8'(d);
                end
                @(negedge clk);
                check("fill_full", tx_full, 1);
                tx_data = 8'h99;
                @(negedge clk);
                tx_start = 1'b0;
                check("fill_full_after_drop", tx_full, 1);
            end
            begin
                for (int d = 1; d <= 5; d++) begin
                    recv(0, CPB);
                    if (!r_timeout) begin
                        check($sformatf("fill_byte_%0d", d), r_bits, {1'b1, 8'(d), 1'b0});
                        check("fill_bit_hold", r_glitch, 0);
                        check("fill_done", r_done_after, 1);
                        if (d > 1) check("fill_no_gap", r_waits, 0);
                    end
                end
            end
        join
        quiet_low = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet_low++;
        end
        check("dropped_byte_absent", quiet_low, 0);

        // Back-to-back pair: 320 cycles total, done pulses 160 apart.
        begin
            int t_first, done1;
            tx_data = 8'h0F; tx_start = 1'b1;
            @(negedge clk);
            tx_data = 8'hF0;
            @(negedge clk);
            tx_start = 1'b0;
            recv(0, CPB);
            t_first = r_t0; done1 = r_t1;
            if (!r_timeout) check("b2b_first", r_bits, 10'b1000011110);
            recv(0, CPB);
            if (!r_timeout) begin
                check("b2b_second", r_bits, 10'b1111100000);
                check("b2b_gap", r_waits, 0);
                check("b2b_total_cycles", r_t1 - t_first, 320);
                check("b2b_done_spacing", r_t1 - done1, 160);
                check("b2b_done2", r_done_after, 1);
            end
        end
        @(negedge clk);

        // Reset during data bit 3 of 0xC3 with 0x11 queued.
        tx_data = 8'hC3; tx_start = 1'b1;
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_start = 1'b0;
        begin
            int w = 0;
            while (tx !== 1'b0 && w < 100) begin @(negedge clk); w++; end
            check("rst_frame_started", tx, 0);
        end
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("rst_mid_bit3_value", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_full", tx_full, 0);
        quiet_low = 0; quiet_done = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet_low++;
            if (tx_done !== 1'b0) quiet_done++;
        end
        check("rst_no_frames", quiet_low, 0);
        check("rst_no_done", quiet_done, 0);

        // Minimum CPB instance.
        write_byte(1, 8'hA5);
        recv(1, CPB2);
        if (!r_timeout) begin
            check("cpb2_frame", r_bits, 10'b1101001010);
            check("cpb2_hold", r_glitch, 0);
            check("cpb2_frame_cycles", r_t1 - r_t0, 20);
            check("cpb2_done", r_done_after, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit-side counterpart of `uart_rx`, sharing its clock, reset and clocks-per-bit (`CPB`) convention. It accepts bytes through a write strobe into a small internal FIFO and emits 8N1 frames on `tx`: one start bit, 8 data bits LSB first, one stop bit, no parity. Frames go out back-to-back while the FIFO holds data. Output `tx` feeds the pad or, in loopback benches, `uart_rx.rx` directly.

## Interface
- `CPB`, 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_data`  in  8  byte to transmit; sampled when `tx_start` is accepted.
- `tx_start`  in  1  write strobe; accepted on an edge where `tx_start=1` and `tx_full=0`.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` bytes; writes ignored.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is on the line (FSM not IDLE).
- `tx_done`  out  1  one-cycle pulse after each frame's stop bit completes.

## Operation
- Reset values (edge with `rst=1`): `tx=1`, `tx_busy=0`, `tx_done=0`, `tx_full=0`. FIFO pointers and count are 0, the baud counter is 0, the bit index is 0 and the FSM is IDLE. Reset overrides all other inputs on that edge.
- FIFO:
  - Circular buffer with a write pointer, a read pointer and a count of width $clog2(FIFO_DEPTH)+1. Pointers wrap modulo `FIFO_DEPTH`.
  - `tx_full` = (count == FIFO_DEPTH), registered from count.
  - A write is accepted only when `tx_full=0` at the sampling edge. A write arriving while full is dropped silently, even if a pop happens on the same edge.
  - A write and a pop on the same edge leave count unchanged.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CPB-1; `bit_end` = (counter == CPB-1).
  - IDLE: `tx=1`. If FIFO is non-empty: pop the head into the shift register, go to START, drive `tx<=0`, clear the counter.
  - START: when `bit_end`, go to DATA with bit index 0 and drive `tx<=shift[0]`.
  - DATA: when `bit_end`, shift right and increment the index. After bit 7, go to STOP with `tx<=1`.
  - STOP: when `bit_end`, assert `tx_done<=1`.
    - If FIFO is non-empty: pop, go to START, `tx<=0` (no idle gap).
    - Otherwise go to IDLE.
- `tx_busy` = (state != IDLE), registered alongside the state.
- Data is latched at pop time. Later writes never alter a frame in flight.

## Timing
- `tx_start` accepted at edge E0 with FIFO empty and FSM IDLE: the FIFO becomes non-empty after E0, and at E1 the FSM pops. `tx` falls and `tx_busy` rises after E1, one cycle of latency.
- Each bit, start and stop included, holds exactly `CPB` cycles. A frame is exactly 10×`CPB` cycles from the `tx` falling edge to the end of the stop bit.
- `tx_done` is high for exactly the one cycle following the final stop-bit edge. With a queued byte, that cycle coincides with the first cycle of the next start bit.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Reset mid-frame: on the next edge `tx=1`, the FIFO empties and no `tx_done` is issued for the aborted frame.
- Glitch-free: `tx` changes only at bit boundaries.

## Test plan
- Single byte, `CPB=16`: write 0x55 -> `tx` low for 16 cycles, then bits 1,0,1,0,1,0,1,0, each 16 cycles, then high for 16 cycles. `tx_done` pulses once, 160 cycles after `tx` falls.
- Loopback into `uart_rx` with `CPB` matched: send 0x55, 0xA3, 0x00, 0xFF -> `rx_data` reports each byte in order with one `rx_done` per byte.
- FIFO fill, `FIFO_DEPTH=4`: five consecutive writes 0x01..0x05 while IDLE. The first is popped after one cycle, so 0x02..0x05 fill the FIFO and `tx_full=1`. Expected line bytes are 0x01..0x05. Repeat with a write issued while `tx_full=1` -> that byte never appears on `tx`.
- Back-to-back: queue 0x0F and 0xF0 -> exactly 320 cycles from the first falling edge to the end of the second stop bit, no idle gap, `tx_done` pulses twice, 160 cycles apart.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 3 of 0xC3 with one byte queued -> `tx=1`, `tx_busy=0`, `tx_full=0` on the next cycle. No `tx_done` and no further frames follow.
- Minimum `CPB=2`: send 0xA5 -> each bit is 2 cycles, frame is 20 cycles, decoded correctly by loopback.
